rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
- Registered N-channel multiplexer where round-robin arbitration replaces the external select.
- Each input channel has a valid/ready handshake. The winning beat is captured into a single output register stage with full throughput.
- Optional packet-lock mode holds the grant on one channel until its last beat, so multi-beat packets are not interleaved.
- Sits between multiple producers and one shared consumer, e.g. request funnels and bus fan-in.

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 4, number of input channels; any value ≥2, power of two not required.
- SIZE, $clog2(CHANNELS), width of the channel index; derived, do not override.
- LOCK, 0, 1 = hold grant from the first beat of a packet until the beat with in_last set is accepted.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  CHANNELS*WIDTH  flattened data; channel i occupies in[i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel beat valid.
- in_last  input  CHANNELS  per-channel end-of-packet flag; used only when LOCK=1.
- in_ready  output  CHANNELS  per-channel accept, one-hot or zero.
- out  output  WIDTH  registered data.
- out_sel  output  SIZE  index of the channel that supplied the registered beat.
- out_last  output  1  registered in_last of that beat.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: out=0, out_sel=0, out_last=0, out_valid=0, ptr=0, locked=0, lock_ch=0. in_ready is 0 while rst is asserted.
- load = !out_valid || out_ready (combinational).

Arbitration (combinational):
- Candidate set: in_valid, masked to lock_ch only when LOCK=1 and locked=1.
- g = the first candidate found by scanning ptr, ptr+1, …, wrapping CHANNELS-1 → 0.
- grant_vld = (candidate set non-zero).
- in_ready[i] = load && grant_vld && (i == g). No in_ready bit depends on in_valid[i] of the same channel beyond the arbitration.
- A channel's transfer occurs when in_valid[i] && in_ready[i].

On a transfer from g:
- out ← in[g], out_sel ← g, out_last ← in_last[g], out_valid ← 1.
- ptr ← g+1, or 0 if g == CHANNELS-1 (explicit wrap; no reliance on power-of-two overflow).

Output register:
- No transfer and out_ready=1: out_valid ← 0.
- No transfer and out_ready=0: hold all output state.
- out_valid=1 with out_ready=1 and a new grant in the same cycle: back-to-back replace. Throughput is 1 beat/cycle.
- Latency: 1 cycle from accepted input to out_valid.

Lock (LOCK=1 only):
- Transfer with in_last[g]=0 and locked=0: locked ← 1, lock_ch ← g.
- Transfer from lock_ch with in_last=1: locked ← 0.
- While locked, other channels receive in_ready=0 even if lock_ch is idle.
- ptr still advances on every beat, so the next arbitration after release starts after lock_ch.
- LOCK=0: locked is tied to 0 and in_last is only forwarded to out_last.

Boundary conditions:
- All in_valid=0: in_ready=0 and no state change except output drain.
- Single requester: it is granted every load cycle, regardless of ptr.
- out_valid=1 with out_ready=0: all in_ready=0 and out is stable (AXI-style hold).
- Reset asserted mid-packet or mid-stall: immediate clear to reset values, lock dropped.

Decomposition:
- Shared package: the SIZE derivation function (clog2 wrapper) and the channel-index slicing helper; both are reused by future arb blocks.
- One natural sub-module, rr_pick: combinational rotating priority picker.
  - Inputs: req[CHANNELS], ptr[SIZE].
  - Outputs: idx[SIZE], any.
  - Instantiated once; unit-testable alone.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with in_valid=4'b1111 → out_valid, out, out_sel, in_ready go to 0 immediately; first post-reset grant is ch0.
- Fairness: CHANNELS=4, all valid continuously, out_ready=1 → out_sel sequence 0,1,2,3,0,1,…; one beat per cycle; in_ready one-hot each cycle.
- Backpressure: out_ready=0 for 3 cycles with out=8'hA5 held → out, out_sel and out_last stable, in_ready=0; on out_ready=1, the next beat loads the same cycle.
- Wrap with non-power-of-two count: CHANNELS=3, only ch2 and ch0 valid → alternating 2,0,2,0; ptr never reaches 3.
- Lock: LOCK=1, ch1 sends 3 beats (last on the 3rd) while ch0 and ch2 are valid → out_sel=1,1,1 then 2; ch1 idle for one mid-packet cycle → no other grant that cycle.
- Reset mid-lock: LOCK=1, rst after beat 1 of a ch3 packet → locked cleared; after release, grant follows ptr=0 priority.

Source files
------------

// File: rtl/rr_arb_mux_pkg.sv
// Shared helpers for the round-robin arbiter blocks: channel-index width
// derivation and per-channel slice offset into a flattened bus.
package rr_arb_mux_pkg;

  function automatic int idx_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int lane_lsb(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/rr_arb_mux_pick.sv
// Rotating-priority picker: first set req bit scanning from ptr upward,
// wrapping at CHANNELS-1 without relying on power-of-two overflow.
module rr_pick
  import rr_arb_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SIZE     = idx_bits(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SIZE-1:0]     ptr,
  output logic [SIZE-1:0]     idx,
  output logic                any
);

  logic [SIZE:0] pos;

  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      pos = {1'b0, ptr} + (SIZE+1)'(k);
      if (pos >= (SIZE+1)'(CHANNELS)) pos = pos - (SIZE+1)'(CHANNELS);
      if (!any && req[pos[SIZE-1:0]]) begin
        any = 1'b1;
        idx = pos[SIZE-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// Registered N:1 mux with round-robin channel selection, valid/ready per
// channel, one output register stage, optional packet lock.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int LOCK     = 0,
  parameter int SIZE     = idx_bits(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out,
  output logic [SIZE-1:0]           out_sel,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [SIZE-1:0]     ptr, lock_ch, g;
  logic                locked, any, load, xfer;
  logic [CHANNELS-1:0] lock_mask, cand, gnt_oh;

  assign load = !out_valid || out_ready;

  always_comb begin
    lock_mask = '0;
    lock_mask[lock_ch] = 1'b1;
    gnt_oh = '0;
    gnt_oh[g] = 1'b1;
  end

  // While a packet is open only its channel may compete, even when idle.
  assign cand = (LOCK != 0 && locked) ? (in_valid & lock_mask) : in_valid;

  rr_pick #(.CHANNELS(CHANNELS), .SIZE(SIZE)) u_pick (
    .req (cand),
    .ptr (ptr),
    .idx (g),
    .any (any)
  );

  assign xfer     = load && any;
  assign in_ready = (!rst && xfer) ? gnt_oh : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      ptr       <= '0;
      locked    <= 1'b0;
      lock_ch   <= '0;
    end else begin
      if (xfer) begin
        out       <= in[lane_lsb(int'(g), WIDTH) +: WIDTH];
        out_sel   <= g;
        out_last  <= in_last[g];
        out_valid <= 1'b1;
        ptr       <= (g == SIZE'(CHANNELS-1)) ? '0 : g + SIZE'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (LOCK != 0 && xfer) begin
        if (!locked && !in_last[g]) begin
          locked  <= 1'b1;
          lock_ch <= g;
        end else if (locked && in_last[g]) begin
          locked  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: 4-channel LOCK=1 instance and 3-channel LOCK=0
// instance driven from vector tables, outputs tracked by a scoreboard queue.
module tb_rr_arb_mux;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        ordy;
    logic [3:0]  exp;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    int         sel;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] in4 = '0;
  logic [3:0]  v4 = '0, l4 = '0, rdy4;
  logic [7:0]  out4;
  logic [1:0]  sel4;
  logic        last4, ov4, or4 = 1'b1;

  logic [23:0] in3 = '0;
  logic [2:0]  v3 = '0, l3 = '0, rdy3;
  logic [7:0]  out3;
  logic [1:0]  sel3;
  logic        last3, ov3, or3 = 1'b1;

  rr_arb_mux #(.WIDTH(8), .CHANNELS(4), .LOCK(1)) u4 (
    .clk(clk), .rst(rst), .in(in4), .in_valid(v4), .in_last(l4), .in_ready(rdy4),
    .out(out4), .out_sel(sel4), .out_last(last4), .out_valid(ov4), .out_ready(or4)
  );

  rr_arb_mux #(.WIDTH(8), .CHANNELS(3), .LOCK(0)) u3 (
    .clk(clk), .rst(rst), .in(in3), .in_valid(v3), .in_last(l3), .in_ready(rdy3),
    .out(out3), .out_sel(sel3), .out_last(last3), .out_valid(ov3), .out_ready(or3)
  );

  int tests = 0, fails = 0, dcnt = 0;
  exp_t q4[$], q3[$];
  vec_t t4[$], t3[$];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] last,
                              input logic ordy, input logic [3:0] exp);
    vec_t v;
    logic [3:0] n;
    dcnt++;
    n = 4'(dcnt);
    v.data = {n, 4'h3, n, 4'h2, n, 4'h1, n, 4'h0};
    v.valid = valid; v.last = last; v.ordy = ordy; v.exp = exp;
    return v;
  endfunction

  task automatic run4(input vec_t v, input string n);
    exp_t e;
    @(negedge clk);
    in4 = v.data; v4 = v.valid; l4 = v.last; or4 = v.ordy;
    #1;
    chk({n, " out_valid"}, 32'(ov4), 32'(q4.size() != 0));
    if (q4.size() != 0) begin
      e = q4[0];
      chk({n, " out"}, 32'(out4), 32'(e.d));
      chk({n, " out_sel"}, 32'(sel4), 32'(e.sel));
      chk({n, " out_last"}, 32'(last4), 32'(e.last));
      if (v.ordy) void'(q4.pop_front());
    end
    chk({n, " in_ready"}, 32'(rdy4), 32'(v.exp));
    for (int c = 0; c < 4; c++)
      if (v.exp[c]) q4.push_back('{v.data[c*8 +: 8], c, v.last[c]});
  endtask

  task automatic run3(input vec_t v, input string n);
    exp_t e;
    @(negedge clk);
    in3 = v.data[23:0]; v3 = v.valid[2:0]; l3 = v.last[2:0]; or3 = v.ordy;
    #1;
    chk({n, " out_valid"}, 32'(ov3), 32'(q3.size() != 0));
    if (q3.size() != 0) begin
      e = q3[0];
      chk({n, " out"}, 32'(out3), 32'(e.d));
      chk({n, " out_sel"}, 32'(sel3), 32'(e.sel));
      chk({n, " out_last"}, 32'(last3), 32'(e.last));
      if (v.ordy) void'(q3.pop_front());
    end
    chk({n, " in_ready"}, 32'(rdy3), 32'(v.exp[2:0]));
    for (int c = 0; c < 3; c++)
      if (v.exp[c]) q3.push_back('{v.data[c*8 +: 8], c, v.last[c]});
  endtask

  task automatic check_reset4(input string n);
    chk({n, " out_valid"}, 32'(ov4), 32'd0);
    chk({n, " out"}, 32'(out4), 32'd0);
    chk({n, " out_sel"}, 32'(sel4), 32'd0);
    chk({n, " in_ready"}, 32'(rdy4), 32'd0);
  endtask

  initial begin
    // fairness, all valid and single-beat packets
    for (int i = 0; i < 7; i++) t4.push_back(mk(4'hF, 4'hF, 1'b1, 4'(1 << ((i) % 4))));
    t4[6].data[23:16] = 8'hA5;
    // backpressure holding the A5 beat from ch2, then reload same cycle
    for (int i = 0; i < 3; i++) t4.push_back(mk(4'hF, 4'hF, 1'b0, 4'h0));
    t4.push_back(mk(4'hF, 4'hF, 1'b1, 4'h8));
    // packet lock on ch1 with a mid-packet idle cycle
    t4.push_back(mk(4'h1, 4'hF, 1'b1, 4'h1));
    t4.push_back(mk(4'h7, 4'hD, 1'b1, 4'h2));
    t4.push_back(mk(4'h7, 4'hD, 1'b1, 4'h2));
    t4.push_back(mk(4'h5, 4'hD, 1'b1, 4'h0));
    t4.push_back(mk(4'h7, 4'hF, 1'b1, 4'h2));
    t4.push_back(mk(4'h5, 4'hF, 1'b1, 4'h4));
    // idle drain, then single requester granted regardless of ptr
    t4.push_back(mk(4'h0, 4'hF, 1'b1, 4'h0));
    t4.push_back(mk(4'h2, 4'hF, 1'b1, 4'h2));
    t4.push_back(mk(4'h2, 4'hF, 1'b1, 4'h2));
    // first beat of a ch3 packet, reset follows
    t4.push_back(mk(4'h8, 4'h0, 1'b1, 4'h8));

    for (int i = 0; i < 4; i++) t3.push_back(mk(4'h5, 4'h0, 1'b1, (i % 2 == 0) ? 4'h1 : 4'h4));
    for (int i = 0; i < 3; i++) t3.push_back(mk(4'h7, 4'h0, 1'b1, 4'(1 << i)));

    // reset held with every channel requesting
    v4 = 4'hF; l4 = 4'hF;
    #2;
    check_reset4("reset");
    v4 = '0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < t4.size(); i++) run4(t4[i], $sformatf("v4[%0d]", i));

    // asynchronous reset mid-cycle, inside the ch3 packet
    @(posedge clk);
    #3;
    v4 = 4'hF; l4 = 4'hF;
    rst = 1'b1;
    #1;
    check_reset4("mid-lock reset");
    q4.delete();
    v4 = '0;
    @(negedge clk);
    rst = 1'b0;
    run4(mk(4'hF, 4'hF, 1'b1, 4'h1), "post-reset");
    run4(mk(4'h0, 4'hF, 1'b1, 4'h0), "post-reset drain");
    run4(mk(4'h0, 4'hF, 1'b1, 4'h0), "post-reset idle");

    for (int i = 0; i < t3.size(); i++) run3(t3[i], $sformatf("v3[%0d]", i));
    run3(mk(4'h0, 4'h0, 1'b1, 4'h0), "v3 drain");
    run3(mk(4'h0, 4'h0, 1'b1, 4'h0), "v3 idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
